// File: rtl/cpu_step_tracer_if.sv
// Readback port of the step tracer: the display/UART side requests an entry/channel
// and receives registered data one cycle later.
interface cpu_step_tracer_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic [CH_W-1:0]   rd_ch;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (output rd_en, rd_idx, rd_ch, input rd_data, rd_valid);
  modport slave  (input rd_en, rd_idx, rd_ch, output rd_data, rd_valid);
endinterface

// File: rtl/cpu_step_tracer.sv
// Single-step / free-run CPU clock-enable gate with PC breakpoint, per-step probe
// capture into a circular trace buffer, PC transition classification and readback.
//
// state    | meaning
// IDLE     | waiting for step_req or run_en
// ISSUE    | cpu_en pulse for one cycle
// CAPTURE  | probe sampled at the edge leaving this state
// HALT     | breakpoint hit; waits for run_en release
module cpu_step_tracer #(
  parameter int DATA_W  = 32,
  parameter int NUM_CH  = 4,
  parameter int DEPTH   = 16,
  parameter int PC_STEP = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_req,
  input  logic                     run_en,
  input  logic                     brk_en,
  input  logic [DATA_W-1:0]        brk_pc,
  input  logic                     clr,
  input  logic [NUM_CH*DATA_W-1:0] probe,
  output logic                     cpu_en,
  output logic                     busy,
  output logic                     halted,
  output logic [1:0]               pc_class,
  output logic [CNT_W-1:0]         step_count,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  cpu_step_tracer_if.slave         rd
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DATA_W-1:0]    PC_INC = DATA_W'(PC_STEP);
  localparam logic [IDX_W:0]       FULL   = (IDX_W+1)'(DEPTH);
  // One bit per encodable channel index; set for indices that name a real channel.
  localparam logic [2**CH_W-1:0]   CH_OK  = {(2**CH_W){1'b1}} >> (2**CH_W - NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_HALT} state_t;

  state_t            state;
  logic              run_flag;
  logic [DATA_W-1:0] pc_now;
  logic              brk_hit;
  logic              capture;
  logic [IDX_W-1:0]  wr_ptr;
  logic [IDX_W-1:0]  oldest;
  logic [IDX_W-1:0]  rd_addr;
  logic              rd_in_range;
  logic [DATA_W-1:0] prev_pc;
  logic              prev_valid;
  logic [DATA_W-1:0] mem [DEPTH][NUM_CH];

  assign pc_now  = probe[DATA_W-1:0];
  assign brk_hit = brk_en && (pc_now == brk_pc);
  assign capture = (state == S_CAPTURE) && !clr;
  // When full, count's low bits are zero, so oldest collapses onto wr_ptr.
  assign oldest  = wr_ptr - count[IDX_W-1:0];
  assign rd_addr = oldest + rd.rd_idx;
  assign rd_in_range = ({1'b0, rd.rd_idx} < count) && CH_OK[rd.rd_ch];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      run_flag <= 1'b0;
      cpu_en   <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      cpu_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (step_req) begin
            state    <= S_ISSUE;
            run_flag <= 1'b0;
            cpu_en   <= 1'b1;
            busy     <= 1'b1;
          end else if (run_en) begin
            state    <= S_ISSUE;
            run_flag <= 1'b1;
            cpu_en   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_ISSUE: begin
          state <= S_CAPTURE;
          busy  <= 1'b1;
        end
        S_CAPTURE: begin
          if (brk_hit) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else if (run_flag && run_en) begin
            state  <= S_ISSUE;
            cpu_en <= 1'b1;
            busy   <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_HALT: begin
          if (!run_en) begin
            state  <= S_IDLE;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      step_count <= '0;
      pc_class   <= 2'b00;
      prev_pc    <= '0;
      prev_valid <= 1'b0;
    end else if (clr) begin
      count      <= '0;
      overflow   <= 1'b0;
      step_count <= '0;
      prev_valid <= 1'b0;
    end else if (capture) begin
      wr_ptr     <= wr_ptr + 1'b1;
      step_count <= step_count + 1'b1;
      prev_pc    <= pc_now;
      prev_valid <= 1'b1;
      if (count == FULL) overflow <= 1'b1;
      else               count    <= count + 1'b1;
      if (!prev_valid)                    pc_class <= 2'b00;
      else if (pc_now == prev_pc + PC_INC) pc_class <= 2'b01;
      else if (pc_now == prev_pc)          pc_class <= 2'b11;
      else                                 pc_class <= 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (capture && !rst) begin
      for (int k = 0; k < NUM_CH; k++) mem[wr_ptr][k] <= probe[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd.rd_valid <= 1'b0;
      rd.rd_data  <= '0;
    end else begin
      rd.rd_valid <= rd.rd_en;
      if (rd.rd_en) rd.rd_data <= rd_in_range ? mem[rd_addr][rd.rd_ch] : '0;
    end
  end
endmodule

// File: tb/tb_cpu_step_tracer.sv
// Directed bench for cpu_step_tracer: single steps, PC classes, run-to-breakpoint,
// overflow wrap, out-of-range reads, and reset/clr in the middle of a step.
module tb_cpu_step_tracer;
  localparam int DATA_W = 32;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;

  logic                     clk = 1'b0;
  logic                     rst, step_req, run_en, brk_en, clr;
  logic [DATA_W-1:0]        brk_pc;
  logic [NUM_CH*DATA_W-1:0] probe;
  logic                     cpu_en, busy, halted, overflow;
  logic [1:0]               pc_class;
  logic [CNT_W-1:0]         step_count;
  logic [$clog2(DEPTH):0]   count;

  int errors = 0;
  int checks = 0;
  int pulses;

  cpu_step_tracer_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) rd_bus ();

  cpu_step_tracer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .PC_STEP(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .step_req(step_req), .run_en(run_en), .brk_en(brk_en),
    .brk_pc(brk_pc), .clr(clr), .probe(probe), .cpu_en(cpu_en), .busy(busy),
    .halted(halted), .pc_class(pc_class), .step_count(step_count), .count(count),
    .overflow(overflow), .rd(rd_bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_probe(input logic [31:0] pc, input logic [31:0] ir);
    probe[31:0]   = pc;
    probe[63:32]  = ir;
    probe[95:64]  = 32'hCAFE_0002;
    probe[127:96] = ~pc;
  endtask

  task automatic do_step(input logic [31:0] pc, input logic [31:0] ir);
    set_probe(pc, ir);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("step_cpu_en_on", cpu_en, 1'b1);
    tick();
    chk("step_cpu_en_off", cpu_en, 1'b0);
    tick();
  endtask

  task automatic rd_check(input string tag, input int idx, input int ch, input logic [31:0] exp);
    rd_bus.rd_en  = 1'b1;
    rd_bus.rd_idx = idx[3:0];
    rd_bus.rd_ch  = ch[1:0];
    tick();
    rd_bus.rd_en = 1'b0;
    chk({tag, "_valid"}, rd_bus.rd_valid, 1'b1);
    chk(tag, rd_bus.rd_data, exp);
  endtask

  initial begin
    rst = 1'b1; step_req = 1'b0; run_en = 1'b0; brk_en = 1'b0; clr = 1'b0;
    brk_pc = '0; probe = '0;
    rd_bus.rd_en = 1'b0; rd_bus.rd_idx = '0; rd_bus.rd_ch = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_cpu_en", cpu_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_step_count", step_count, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_rd_valid", rd_bus.rd_valid, 1'b0);
    chk("rst_rd_data", rd_bus.rd_data, 0);

    // first single step
    do_step(32'h0, 32'h0050_0093);
    chk("s1_class", pc_class, 2'b00);
    chk("s1_step_count", step_count, 1);
    chk("s1_count", count, 1);
    chk("s1_busy", busy, 1'b0);
    rd_check("s1_rd_ch0", 0, 0, 32'h0);
    rd_check("s1_rd_ch1", 0, 1, 32'h0050_0093);

    // PC classification
    do_step(32'h4, 32'h11);
    chk("s2_class_seq", pc_class, 2'b01);
    do_step(32'h8, 32'h22);
    chk("s3_class_seq", pc_class, 2'b01);
    do_step(32'h20, 32'h33);
    chk("s4_class_jump", pc_class, 2'b10);
    do_step(32'h20, 32'h44);
    chk("s5_class_stall", pc_class, 2'b11);
    chk("s5_step_count", step_count, 5);
    chk("s5_count", count, 5);
    rd_check("s5_rd_ch3", 3, 3, ~32'h20);

    // free-run to breakpoint; PC advances by 4 per cpu_en pulse
    set_probe(32'h0, 32'h0);
    brk_pc = 32'h10; brk_en = 1'b1; run_en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cpu_en) begin
        pulses++;
        set_probe(probe[31:0] + 32'h4, 32'h0);
      end
      if (halted) break;
    end
    chk("brk_halted", halted, 1'b1);
    chk("brk_pulses", pulses, 4);
    chk("brk_step_count", step_count, 9);
    chk("brk_class", pc_class, 2'b01);
    chk("brk_busy", busy, 1'b0);
    pulses = 0;
    step_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      step_req = 1'b0;
      if (cpu_en) pulses++;
    end
    chk("halt_no_cpu_en", pulses, 0);
    chk("halt_held", halted, 1'b1);
    chk("halt_step_count", step_count, 9);
    run_en = 1'b0;
    tick();
    chk("halt_release", halted, 1'b0);
    tick();
    chk("idle_after_halt_cpu_en", cpu_en, 1'b0);
    rd_check("brk_rd_last_pc", 8, 0, 32'h10);
    brk_en = 1'b0;

    // overflow: DEPTH+3 captures
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_step_count", step_count, 0);
    for (int i = 0; i < DEPTH + 3; i++) do_step(32'(4 * i), 32'(32'h1000 + i));
    chk("ovf_count", count, DEPTH);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_step_count", step_count, DEPTH + 3);
    chk("ovf_class", pc_class, 2'b01);
    rd_check("ovf_oldest_pc", 0, 0, 32'hC);
    rd_check("ovf_oldest_ir", 0, 1, 32'h1003);
    rd_check("ovf_newest_pc", 15, 0, 32'h48);

    // out-of-range read returns zero
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr2_overflow", overflow, 1'b0);
    do_step(32'h200, 32'h55);
    chk("clr2_first_class", pc_class, 2'b00);
    rd_check("oor_in_range", 0, 1, 32'h55);
    rd_check("oor_idx_eq_count", 1, 0, 32'h0);

    // reset during ISSUE
    set_probe(32'h300, 32'h66);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("rst_mid_cpu_en_before", cpu_en, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_cpu_en", cpu_en, 1'b0);
    chk("rst_mid_count", count, 0);
    tick(); tick();
    chk("rst_mid_no_capture", count, 0);
    do_step(32'h100, 32'h77);
    chk("rst_mid_next_class", pc_class, 2'b00);

    // clr during CAPTURE discards the capture and invalidates prev_pc
    set_probe(32'h104, 32'h88);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_cap_cpu_en", cpu_en, 1'b0);
    chk("clr_cap_count", count, 0);
    chk("clr_cap_step_count", step_count, 0);
    do_step(32'h108, 32'h99);
    chk("clr_cap_next_class", pc_class, 2'b00);

    // sequential wrap at the top of the address space
    do_step(32'hFFFF_FFFC, 32'h1);
    chk("wrap_pre_class", pc_class, 2'b10);
    do_step(32'h0, 32'h2);
    chk("wrap_class_seq", pc_class, 2'b01);
    chk("wrap_count", count, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_step_tracer.md
Name: cpu_step_tracer

Overview:
- Board-level debug block between the manual step key and the multi-cycle CPU. It gates the CPU clock-enable for single-step or free-run with a PC breakpoint.
- After every step it captures NUM_CH probe words (channel 0 = PC; typically IR, MDR, W_Data) into a circular trace buffer.
- It classifies each PC transition and offers a registered readback port for the display/UART logic.

Parameters:
- DATA_W, 32, width of each probe channel
- NUM_CH, 4, number of probe channels captured per step (>=1; ch0 must be PC)
- DEPTH, 16, trace entries (power of two, >=2)
- PC_STEP, 4, sequential PC increment
- CNT_W, 16, step counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- step_req  in  1  one-cycle pulse from the debounced step key
- run_en  in  1  level; 1 = free-run mode
- brk_en  in  1  enable PC breakpoint
- brk_pc  in  DATA_W  breakpoint PC
- clr  in  1  pulse; empty trace, clear overflow and step_count
- probe  in  NUM_CH*DATA_W  probe bus; ch k = bits [k*DATA_W +: DATA_W]
- cpu_en  out  1  registered CPU clock-enable, one-cycle pulse per step
- busy  out  1  state != IDLE and != HALT
- halted  out  1  state == HALT
- pc_class  out  2  class of last captured PC: 00 first, 01 seq, 10 jump, 11 stall
- step_count  out  CNT_W  completed captures, wraps mod 2^CNT_W
- count  out  $clog2(DEPTH)+1  valid entries, 0..DEPTH
- overflow  out  1  sticky; set when an entry is overwritten
- rd_en  in  1  read request
- rd_idx  in  $clog2(DEPTH)  entry index, 0 = oldest
- rd_ch  in  $clog2(NUM_CH) (min 1)  channel select
- rd_data  out  DATA_W  read data, valid the cycle after rd_en
- rd_valid  out  1  one-cycle pulse, aligned with rd_data

Behaviour:
- Reset values:
  - All outputs 0; state = IDLE.
  - Write pointer 0, prev_pc invalid.
  - Reset mid-step: cpu_en is 0 from the next edge and no capture occurs.
- State machine (all outputs registered):
  - IDLE:
    - step_req → ISSUE.
    - Else if run_en → ISSUE (run flag set).
    - step_req while not IDLE is ignored.
  - ISSUE:
    - cpu_en = 1 for exactly this one cycle → CAPTURE.
  - CAPTURE:
    - Sample probe at this edge, i.e. one cycle after the cpu_en pulse.
    - Write the entry and update pc_class, prev_pc and step_count (+1).
    - Next state:
      - brk_en && ch0 == brk_pc → HALT.
      - Else run flag && run_en → ISSUE.
      - Else → IDLE.
    - Consequence: a single step takes 3 cycles from step_req to the capture writing the entry; free-run gives one step per 2 cycles.
  - HALT:
    - halted = 1, cpu_en = 0.
    - Leaves to IDLE only when run_en == 0.
    - step_req while HALT is ignored; run_en must be released first.
  - run_en deasserted during ISSUE or CAPTURE: the step in progress completes, then → IDLE.
- PC classification (mod 2^DATA_W arithmetic):
  - First capture after rst or clr → 00.
  - pc == prev_pc + PC_STEP → 01, including wrap from 2^DATA_W − PC_STEP to 0.
  - pc == prev_pc → 11.
  - Otherwise → 10.
- Trace buffer:
  - Circular, DEPTH × NUM_CH × DATA_W.
  - count saturates at DEPTH.
  - Capture when full overwrites the oldest entry, sets overflow, and advances the oldest pointer; count stays DEPTH.
- Read port:
  - rd_data = entry ((oldest + rd_idx) mod DEPTH), channel rd_ch, registered, 1-cycle latency.
  - rd_idx >= count or rd_ch >= NUM_CH → rd_data = 0, rd_valid still pulses.
  - Read in the same cycle as a capture returns pre-capture contents and ordering.
- clr:
  - Same cycle as a capture: clr wins; that capture is discarded, count = 0, and prev_pc becomes invalid.
  - clr does not change the state machine.

Test Plan:
- Reset, then step_req once with probe ch0=0x0, ch1=0x00500093 → cpu_en high for 1 cycle at cycle 2; entry 0 = {0x0, 0x00500093}; pc_class=00; step_count=1; count=1.
- Three further steps with PC 0x4, 0x8, 0x20 → pc_class 01, 01, 10; a repeat of 0x20 → 11; step_count=5.
- run_en=1, brk_en=1, brk_pc=0x10, PC advancing +4 per cpu_en → halted=1 after the capture of PC 0x10; no cpu_en while halted; releasing run_en → IDLE.
- DEPTH+3 captures with PC = 4·i → count=DEPTH, overflow=1; rd_idx=0, rd_ch=0 returns 0xC.
- Out-of-range read (rd_idx=count, or rd_ch=NUM_CH) → rd_data=0 with rd_valid=1.
- Assert rst during ISSUE, and separately clr during CAPTURE → next-cycle cpu_en=0 and count=0; the following step reports pc_class=00.
